pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Drives the hold/flush side of the pipeline registers. Detects load-use hazards and taken branches.
//  Sequences multi-cycle EX ops (div) with a countdown FSM, and applies data-bus wait and trap stalls/flushes.
//  stall_* outputs freeze stage registers; flush_* outputs drive their hold_i so they load the bubble value.
//  Sits beside the decoder and EX unit; a single instance per core.
// PARAMETERS
//  REG_ADDR_W  5   register-index width
//  MC_CYCLES   32  total stall cycles for a multi-cycle EX op; must be >= 2
//  CNT_W       6   countdown width; must satisfy 2**CNT_W > MC_CYCLES-1
//  PERF_W      32  stall perf counter width (only with BUCEROS_STALL_PERF_EN)
// PORTS
//  clk               in   1           core clock, rising edge
//  rst_n             in   1           synchronous, active-low reset
//  id_rs1_i/id_rs2_i in   REG_ADDR_W  source regs of instr in ID
//  id_rs1_used_i     in   1           ID instr reads rs1
//  id_rs2_used_i     in   1           ID instr reads rs2
//  ex_rd_i           in   REG_ADDR_W  dest reg of instr in EX
//  ex_load_i         in   1           EX instr is a load
//  ex_mc_start_i     in   1           EX instr is a multi-cycle op
//  ex_branch_taken_i in   1           EX resolved a taken branch/jump
//  mem_wait_i        in   1           data bus not ready; MEM must hold
//  trap_i            in   1           trap/interrupt redirect this cycle
//  stall_pc_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o  out 1  hold stage register
//  flush_id_o, flush_ex_o, flush_mem_o                          out 1  bubble into IF/ID, ID/EX, EX/MEM
//  mc_busy_o         out  1           multi-cycle op in progress (state==MC)
// BEHAVIOUR
//  - State regs: state {RUN, MC}, cnt[CNT_W]. Reset (rst_n=0 at clk edge): state=RUN, cnt=0.
//  - All outputs are combinational from state, cnt and inputs. While rst_n=0 every output is forced 0.
//  - Priority, highest first: trap > mem_wait > mc > branch > load-use.
//  - trap_i: flush_id/ex/mem=1, all stalls=0. Next state RUN, cnt=0; this aborts any MC op.
//  - mem_wait_i (no trap): stall_pc..stall_mem=1, no flushes. FSM frozen; cnt does not decrement.
//  - RUN & ex_mc_start_i: stall_pc/if/id/ex=1, flush_mem=1. Next state MC, cnt=MC_CYCLES-1.
//  - MC & cnt!=0: same stalls/flush as above; cnt<=cnt-1. ex_mc_start_i and branch are ignored.
//  - MC & cnt==0: no stall/flush; the op retires from EX. Next state RUN.
//    The start input is ignored in this cycle; total stall cycles = MC_CYCLES exactly.
//  - ex_branch_taken_i (RUN, no mc start): flush_id=1, flush_ex=1, stalls=0.
//    This overrides a simultaneous load-use hazard.
//  - Load-use (RUN): ex_load_i & ex_rd_i!=0 & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)).
//    Response: stall_pc/if/id=1, flush_ex=1, for exactly 1 cycle; the load then advances to MEM.
//  - x0 (rd==0) never raises a load-use hazard. ex_mc_start_i and ex_branch_taken_i are mutually exclusive;
//    if both are set, mc wins.
// CONFIGURATION
//  - BUCEROS_STALL_PERF_EN defined: add port perf_stall_cnt_o (out, PERF_W).
//    It counts cycles with stall_pc_o=1, saturates at all-ones, and resets to 0.
//  - Not defined: port and counter absent; no other behaviour changes.
// STRUCTURE
//  - State encodings (RUN=1'b0, MC=1'b1) and MC_CYCLES default go in buceros_header.v as `defines.
//  - One sub-module: hazard_mc_cnt, a loadable down-counter with freeze input and zero flag.
//  - Load-use compare stays inline.
// TESTING
//  1. Reset, all inputs 0 -> all outputs 0, mc_busy_o=0.
//  2. Load-use: ex_load=1, ex_rd=5, id_rs1=5, rs1_used=1 -> stall_pc/if/id=1, flush_ex=1 for 1 cycle.
//     Same with ex_rd=0 -> no stall.
//  3. MC: MC_CYCLES=4, one-cycle pulse style ex_mc_start held -> stalls high for exactly 4 cycles,
//     flush_mem high during them, release on 5th.
//  4. mem_wait=1 for 3 cycles mid-MC -> all stalls high, count frozen. MC stall total becomes MC_CYCLES+3.
//  5. trap_i at MC cnt=2 -> flush_id/ex/mem=1, stalls 0, mc_busy_o=0 next cycle.
//     Branch+load-use together -> flush_id/ex only, no stall.
//  6. BUCEROS_STALL_PERF_EN, PERF_W=3: 10 stall cycles -> perf_stall_cnt_o saturates at 7.
//     Synchronous reset mid-MC -> RUN, counter 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_hazard_ctrl_pkg : shared state encoding, control bundle and defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MC  = 1'b1
  } hz_state_t;

  localparam int MC_CYCLES_DEF = 32;

  typedef struct packed {
    logic stall_pc;
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic flush_mem;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE     = 8'b00000_000;
  localparam hz_ctrl_t CTRL_TRAP     = 8'b00000_111;
  localparam hz_ctrl_t CTRL_MEM_WAIT = 8'b11111_000;
  localparam hz_ctrl_t CTRL_MC       = 8'b11110_001;
  localparam hz_ctrl_t CTRL_BRANCH   = 8'b00000_110;
  localparam hz_ctrl_t CTRL_LOAD_USE = 8'b11100_010;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// pipe_hazard_ctrl_if : pipeline-side hazard inputs and hold/flush outputs
// Rev 1.0   (perf port present with BUCEROS_STALL_PERF_EN)
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
`ifdef BUCEROS_STALL_PERF_EN
  , parameter int PERF_W = 32
`endif
);

  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_rs1_used_i;
  logic                  id_rs2_used_i;
  logic [REG_ADDR_W-1:0] ex_rd_i;
  logic                  ex_load_i;
  logic                  ex_mc_start_i;
  logic                  ex_branch_taken_i;
  logic                  mem_wait_i;
  logic                  trap_i;

  logic stall_pc_o;
  logic stall_if_o;
  logic stall_id_o;
  logic stall_ex_o;
  logic stall_mem_o;
  logic flush_id_o;
  logic flush_ex_o;
  logic flush_mem_o;
  logic mc_busy_o;
`ifdef BUCEROS_STALL_PERF_EN
  logic [PERF_W-1:0] perf_stall_cnt_o;
`endif

  modport master (
    output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
           ex_load_i, ex_mc_start_i, ex_branch_taken_i, mem_wait_i, trap_i,
    input  stall_pc_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
           flush_id_o, flush_ex_o, flush_mem_o, mc_busy_o
`ifdef BUCEROS_STALL_PERF_EN
           , perf_stall_cnt_o
`endif
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
           ex_load_i, ex_mc_start_i, ex_branch_taken_i, mem_wait_i, trap_i,
    output stall_pc_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
           flush_id_o, flush_ex_o, flush_mem_o, mc_busy_o
`ifdef BUCEROS_STALL_PERF_EN
           , perf_stall_cnt_o
`endif
  );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mc_cnt.sv
// ============================================================================
// hazard_mc_cnt : loadable down-counter with clear, freeze and zero flag
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_mc_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             freeze,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // clear (trap) beats freeze (bus wait), which beats load/decrement
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : pipeline hold/flush control (load-use, branch, multi-cycle
// EX, bus wait, trap). Option BUCEROS_STALL_PERF_EN adds a stall-cycle counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MC_CYCLES  = MC_CYCLES_DEF,
  parameter int CNT_W      = 6
`ifdef BUCEROS_STALL_PERF_EN
  , parameter int PERF_W   = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  hz_state_t             state_q;
  hz_state_t             state_d;
  hz_ctrl_t              ctrl;
  logic                  mc_load;
  logic                  mc_zero;
  logic                  load_use;
  logic [REG_ADDR_W-1:0] ex_rd;

  assign ex_rd = hz.ex_rd_i;

  assign load_use = hz.ex_load_i && (ex_rd != '0) &&
                    ((hz.id_rs1_used_i && (hz.id_rs1_i == ex_rd)) ||
                     (hz.id_rs2_used_i && (hz.id_rs2_i == ex_rd)));

  hazard_mc_cnt #(
    .CNT_W (CNT_W)
  ) u_mc_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (hz.trap_i),
    .freeze   (hz.mem_wait_i),
    .load     (mc_load),
    .load_val (CNT_W'(MC_CYCLES - 1)),
    .dec      (state_q == ST_MC),
    .zero     (mc_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_NONE;
    mc_load = 1'b0;
    if (!rst_n) begin
      state_d = ST_RUN;
    end else if (hz.trap_i) begin
      ctrl    = CTRL_TRAP;
      state_d = ST_RUN;
    end else if (hz.mem_wait_i) begin
      ctrl    = CTRL_MEM_WAIT;
    end else if (state_q == ST_MC) begin
      // the zero-count cycle is the one in which the op leaves EX
      if (!mc_zero) begin
        ctrl    = CTRL_MC;
      end else begin
        state_d = ST_RUN;
      end
    end else if (hz.ex_mc_start_i) begin
      ctrl    = CTRL_MC;
      mc_load = 1'b1;
      state_d = ST_MC;
    end else if (hz.ex_branch_taken_i) begin
      ctrl    = CTRL_BRANCH;
    end else if (load_use) begin
      ctrl    = CTRL_LOAD_USE;
    end
  end

  assign hz.stall_pc_o  = ctrl.stall_pc;
  assign hz.stall_if_o  = ctrl.stall_if;
  assign hz.stall_id_o  = ctrl.stall_id;
  assign hz.stall_ex_o  = ctrl.stall_ex;
  assign hz.stall_mem_o = ctrl.stall_mem;
  assign hz.flush_id_o  = ctrl.flush_id;
  assign hz.flush_ex_o  = ctrl.flush_ex;
  assign hz.flush_mem_o = ctrl.flush_mem;
  assign hz.mc_busy_o   = rst_n && (state_q == ST_MC);

`ifdef BUCEROS_STALL_PERF_EN
  logic [PERF_W-1:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (ctrl.stall_pc && (perf_cnt != '1)) begin
      perf_cnt <= perf_cnt + PERF_W'(1);
    end
  end

  assign hz.perf_stall_cnt_o = rst_n ? perf_cnt : '0;
`endif

endmodule

`default_nettype wire
